// File: rtl/ram_arb_pkg.sv
// Shared types and sizes for the two-client RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W           = 5;
  localparam int unsigned DATA_W           = 4;
  localparam int unsigned READ_LATENCY_DEF = 2;

  typedef enum logic {
    CLI_A = 1'b0,
    CLI_B = 1'b1
  } client_t;

  // One slot of the read-latency pipe: is a result due, and for whom.
  typedef struct packed {
    logic    valid;
    client_t id;
  } rd_tag_t;

  // Map a one-hot (or empty) grant vector to the winning client.
  function automatic client_t winner(input logic [1:0] gnt);
    return gnt[1] ? CLI_B : CLI_A;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a last-granted pointer.
// The grant is combinational from the requests; the pointer moves to the winner
// only when upd_en_i is high, so a grant the caller later suppresses does not
// cost the loser its turn.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       upd_en_i,
  output logic [1:0] gnt_o
);

  client_t last_q, last_d;

  // Grant selection: single requester wins outright, contention goes to the non-last client.
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == CLI_A) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Pointer update: follow the winner when the grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (upd_en_i && (|gnt_o)) begin
      last_d = winner(gnt_o);
    end
  end

  // Pointer register; reset marks B as last so A is preferred first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= CLI_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a dual-port RAM (separate read/write ports, registered inputs and
// output) between requesters A and B. Each cycle at most one write and one
// read are issued, each port with its own round-robin pointer. A read that
// targets the address being written this cycle is held off one cycle, since
// mixed-port read-during-write is undefined on the RAM. Read results are
// returned on the shared rdata with a per-client valid strobe, tracked by a
// tag pipe matching the RAM read latency.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,

  output logic [DATA_W-1:0] rdata,

  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_q
);

  logic [1:0]        wr_req;
  logic [1:0]        wr_arb_gnt;
  logic [1:0]        wr_gnt;
  logic              wr_any;

  logic [1:0]        rd_req;
  logic [1:0]        rd_arb_gnt;
  logic [1:0]        rd_gnt;
  logic [ADDR_W-1:0] rd_cand_addr;
  logic              rd_hazard;

  rd_tag_t [READ_LATENCY-1:0] pipe_q, pipe_d;

  assign wr_req = {b_req & b_we, a_req & a_we};
  assign rd_req = {b_req & ~b_we, a_req & ~a_we};

  rr_arbiter2 u_wr_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (wr_req),
    .upd_en_i (reset_n),
    .gnt_o    (wr_arb_gnt)
  );

  rr_arbiter2 u_rd_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (rd_req),
    .upd_en_i (reset_n & ~rd_hazard),
    .gnt_o    (rd_arb_gnt)
  );

  // Write port: gate grant during reset and steer the winner onto the RAM.
  always_comb begin
    wr_gnt        = wr_arb_gnt & {2{reset_n}};
    wr_any        = |wr_gnt;
    ram_wren      = wr_any;
    ram_wraddress = wr_gnt[1] ? b_addr  : a_addr;
    ram_data      = wr_gnt[1] ? b_wdata : a_wdata;
  end

  // Read port: stall the read winner when it collides with this cycle's write.
  always_comb begin
    rd_cand_addr  = rd_arb_gnt[1] ? b_addr : a_addr;
    rd_hazard     = wr_any && (rd_cand_addr == ram_wraddress);
    rd_gnt        = rd_arb_gnt & {2{reset_n & ~rd_hazard}};
    ram_rdaddress = rd_cand_addr;
  end

  // Client grants: each client has at most one op pending, on one port.
  always_comb begin
    a_gnt = wr_gnt[0] | rd_gnt[0];
    b_gnt = wr_gnt[1] | rd_gnt[1];
  end

  // Latency pipe next state: push the read grant, shift older tags along.
  always_comb begin
    pipe_d          = pipe_q;
    pipe_d[0].valid = |rd_gnt;
    pipe_d[0].id    = winner(rd_gnt);
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Latency pipe register; reset drops reads in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Result decode: the oldest tag lines up with the RAM output register.
  always_comb begin
    a_rvalid = pipe_q[READ_LATENCY-1].valid && (pipe_q[READ_LATENCY-1].id == CLI_A);
    b_rvalid = pipe_q[READ_LATENCY-1].valid && (pipe_q[READ_LATENCY-1].id == CLI_B);
    rdata    = ram_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x4 RAM
// (registered read address and registered output, registered write).
module tb_ram_port_arbiter;

  logic       clk;
  logic       reset_n;
  logic       a_req, a_we, b_req, b_we;
  logic [4:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [3:0] rdata;
  logic [4:0] ram_wraddress, ram_rdaddress;
  logic [3:0] ram_data, ram_q;
  logic       ram_wren;

  int total = 0;
  int bad   = 0;

  ram_port_arbiter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .a_req         (a_req),
    .a_we          (a_we),
    .a_addr        (a_addr),
    .a_wdata       (a_wdata),
    .a_gnt         (a_gnt),
    .a_rvalid      (a_rvalid),
    .b_req         (b_req),
    .b_we          (b_we),
    .b_addr        (b_addr),
    .b_wdata       (b_wdata),
    .b_gnt         (b_gnt),
    .b_rvalid      (b_rvalid),
    .rdata         (rdata),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .ram_rdaddress (ram_rdaddress),
    .ram_q         (ram_q)
  );

  // RAM model
  logic [3:0] mem [32];
  logic [4:0] rdaddr_q;
  logic [3:0] q_q;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 4'h0;
    rdaddr_q = 5'd0;
    q_q      = 4'h0;
  end

  always @(posedge clk) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    rdaddr_q <= ram_rdaddress;
    q_q      <= mem[rdaddr_q];
  end
  assign ram_q = q_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv_a(input logic req, input logic we, input logic [4:0] addr, input logic [3:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drv_b(input logic req, input logic we, input logic [4:0] addr, input logic [3:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  // drive point: just after the active edge
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // sample point: opposite edge
  task automatic smp();
    @(negedge clk);
  endtask

  logic [3:0] exp_mem [8];
  int a_idx, b_idx;

  initial begin
    exp_mem[0] = 4'hF; exp_mem[1] = 4'hA; exp_mem[2] = 4'h1; exp_mem[3] = 4'h5;
    exp_mem[4] = 4'h6; exp_mem[5] = 4'h0; exp_mem[6] = 4'h0; exp_mem[7] = 4'h9;

    reset_n = 1'b0;
    drv_a(1'b1, 1'b0, 5'd0, 4'h0);
    drv_b(1'b0, 1'b0, 5'd0, 4'h0);
    repeat (2) next_cyc();
    smp();
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_a_gnt",    32'(a_gnt),    32'd0);

    // 1: read in flight, then reset drops it
    next_cyc();
    reset_n = 1'b1;
    smp();
    chk("t1_rd_gnt", 32'(a_gnt), 32'd1);
    next_cyc();
    reset_n = 1'b0;
    drv_a(1'b1, 1'b1, 5'd3, 4'h5);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t1_rst_a_rvalid", 32'(a_rvalid), 32'd0);
      chk("t1_rst_b_rvalid", 32'(b_rvalid), 32'd0);
      chk("t1_rst_a_gnt",    32'(a_gnt),    32'd0);
      chk("t1_rst_wren",     32'(ram_wren), 32'd0);
      next_cyc();
    end
    reset_n = 1'b1;
    smp();
    chk("t1_wr_gnt",   32'(a_gnt),         32'd1);
    chk("t1_wren",     32'(ram_wren),      32'd1);
    chk("t1_wraddr",   32'(ram_wraddress), 32'd3);
    chk("t1_wdata",    32'(ram_data),      32'h5);

    // B alone writes addr 4 so wr pointer marks B as last
    next_cyc();
    drv_a(1'b0, 1'b0, 5'd0, 4'h0);
    drv_b(1'b1, 1'b1, 5'd4, 4'h6);
    smp();
    chk("pre2_b_gnt", 32'(b_gnt), 32'd1);
    chk("pre2_a_gnt", 32'(a_gnt), 32'd0);

    // 2: write contention
    next_cyc();
    drv_a(1'b1, 1'b1, 5'd0, 4'hF);
    drv_b(1'b1, 1'b1, 5'd1, 4'hA);
    smp();
    chk("t2_c0_a_gnt", 32'(a_gnt), 32'd1);
    chk("t2_c0_b_gnt", 32'(b_gnt), 32'd0);
    chk("t2_c0_addr",  32'(ram_wraddress), 32'd0);
    chk("t2_c0_data",  32'(ram_data), 32'hF);
    next_cyc();
    drv_a(1'b0, 1'b0, 5'd0, 4'h0);
    smp();
    chk("t2_c1_b_gnt", 32'(b_gnt), 32'd1);
    chk("t2_c1_addr",  32'(ram_wraddress), 32'd1);
    chk("t2_c1_data",  32'(ram_data), 32'hA);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      drv_a(1'b1, 1'b1, 5'd0, 4'hF);
      drv_b(1'b1, 1'b1, 5'd1, 4'hA);
      smp();
      chk("t2_alt_a_gnt", 32'(a_gnt), 32'((i % 2) == 0));
      chk("t2_alt_b_gnt", 32'(b_gnt), 32'((i % 2) == 1));
    end

    // 3: read latency
    next_cyc();
    drv_a(1'b1, 1'b0, 5'd0, 4'h0);
    drv_b(1'b0, 1'b0, 5'd0, 4'h0);
    smp();
    chk("t3_a_gnt", 32'(a_gnt), 32'd1);
    next_cyc();
    drv_a(1'b0, 1'b0, 5'd0, 4'h0);
    smp();
    chk("t3_t1_a_rvalid", 32'(a_rvalid), 32'd0);
    next_cyc();
    smp();
    chk("t3_a_rvalid", 32'(a_rvalid), 32'd1);
    chk("t3_rdata",    32'(rdata),    32'hF);
    chk("t3_b_rvalid", 32'(b_rvalid), 32'd0);

    // 4: same-address hazard
    next_cyc();
    drv_a(1'b1, 1'b1, 5'd7, 4'h9);
    drv_b(1'b1, 1'b0, 5'd7, 4'h0);
    smp();
    chk("t4_a_gnt", 32'(a_gnt), 32'd1);
    chk("t4_b_stall", 32'(b_gnt), 32'd0);
    next_cyc();
    drv_a(1'b0, 1'b0, 5'd0, 4'h0);
    smp();
    chk("t4_b_gnt", 32'(b_gnt), 32'd1);
    chk("t4_rdaddr", 32'(ram_rdaddress), 32'd7);
    next_cyc();
    drv_b(1'b0, 1'b0, 5'd0, 4'h0);
    smp();
    chk("t4_t1_b_rvalid", 32'(b_rvalid), 32'd0);
    next_cyc();
    smp();
    chk("t4_b_rvalid", 32'(b_rvalid), 32'd1);
    chk("t4_rdata",    32'(rdata),    32'h9);
    chk("t4_a_rvalid", 32'(a_rvalid), 32'd0);

    // 5: write and read granted in parallel
    next_cyc();
    drv_a(1'b1, 1'b1, 5'd2, 4'h1);
    drv_b(1'b1, 1'b0, 5'd0, 4'h0);
    smp();
    chk("t5_a_gnt", 32'(a_gnt), 32'd1);
    chk("t5_b_gnt", 32'(b_gnt), 32'd1);
    chk("t5_wren",  32'(ram_wren), 32'd1);
    next_cyc();
    drv_a(1'b0, 1'b0, 5'd0, 4'h0);
    drv_b(1'b0, 1'b0, 5'd0, 4'h0);
    next_cyc();
    smp();
    chk("t5_b_rvalid", 32'(b_rvalid), 32'd1);
    chk("t5_rdata",    32'(rdata),    32'hF);

    // 6: streaming reads, A and B each over addrs 0..7
    a_idx = 0;
    b_idx = 0;
    for (int k = 0; k < 18; k++) begin
      next_cyc();
      drv_a(a_idx < 8, 1'b0, 5'(a_idx), 4'h0);
      drv_b(b_idx < 8, 1'b0, 5'(b_idx), 4'h0);
      smp();
      if (k < 16) begin
        chk("t6_a_gnt",  32'(a_gnt), 32'((k % 2) == 0));
        chk("t6_b_gnt",  32'(b_gnt), 32'((k % 2) == 1));
        chk("t6_rdaddr", 32'(ram_rdaddress), 32'(k / 2));
      end
      if (k >= 2) begin
        chk("t6_a_rvalid", 32'(a_rvalid), 32'(((k - 2) % 2) == 0));
        chk("t6_b_rvalid", 32'(b_rvalid), 32'(((k - 2) % 2) == 1));
        chk("t6_rdata",    32'(rdata),    32'(exp_mem[(k - 2) / 2]));
      end
      if (a_gnt) a_idx++;
      if (b_gnt) b_idx++;
    end
    next_cyc();
    smp();
    chk("t6_drain_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("t6_drain_b_rvalid", 32'(b_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
